// File: rtl/mult_share_pkg.sv
// ---------------------------------------------------------------------------
// mult_share_pkg
// Shared definitions for the round-robin multiplier scheduler (mult_share_rr)
// and its arbiter (rr_arbiter):
//   - state_t        : scheduler FSM states
//   - DEFAULT_DATA_WIDTH / PROD_WIDTH : default operand and product widths
//   - rr_next_ptr()  : next round-robin start position after a winner
// ---------------------------------------------------------------------------
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        MUL2 = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam int DEFAULT_DATA_WIDTH = 2;
    localparam int PROD_WIDTH         = 2 * DEFAULT_DATA_WIDTH;

    // The requester after the winner gets first look next time; the last
    // requester wraps back to requester 0.
    function automatic int rr_next_ptr(input int winner, input int num_req);
        return (winner >= num_req - 1) ? 0 : winner + 1;
    endfunction

endpackage

// File: rtl/mult_share_rr_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans req_valid starting at rr_ptr and
// wrapping modulo NUM_REQ; the first valid requester wins.
// Ports:
//   req_valid   in  NUM_REQ   request bits
//   rr_ptr      in  ID_WIDTH  index scanned first
//   grant       out NUM_REQ   one-hot grant (all zero when nothing is valid)
//   grant_id    out ID_WIDTH  index of the winner (0 when none)
//   grant_found out 1         a winner exists
// ---------------------------------------------------------------------------
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]  req_valid,
    input  logic [ID_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] grant_id,
    output logic                grant_found
);

    int                  idx;
    logic [ID_WIDTH-1:0] sel;

    // Walk the requesters in priority order from rr_ptr; only the first
    // valid one encountered is granted.
    always_comb begin
        grant       = '0;
        grant_id    = '0;
        grant_found = 1'b0;
        idx         = 0;
        sel         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            sel = ID_WIDTH'(idx);
            if (!grant_found && req_valid[sel]) begin
                grant[sel]  = 1'b1;
                grant_id    = sel;
                grant_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mult_share_rr.sv
// ---------------------------------------------------------------------------
// mult_share_rr
// Shares one DATA_WIDTH x DATA_WIDTH unsigned multiplier among NUM_REQ
// requesters. One request is granted at a time (round robin), its operands
// are registered, multiplied, and the product is returned tagged with the
// requester index.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   req_valid    in  NUM_REQ              per-requester valid
//   req_ready    out NUM_REQ              one-hot grant, only in IDLE
//   req_a/req_b  in  NUM_REQ*DATA_WIDTH   operands, requester i at
//                                         [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid    out 1                    result valid (RESP state)
//   rsp_ready    in  1                    consumer accepts result
//   rsp_id       out ID_WIDTH             owner of the result
//   rsp_y        out 2*DATA_WIDTH         full-width product
//   busy         out 1                    FSM not in IDLE
// Build option: define MULT_SHARE_PIPE_EN to add the MUL2 stage, which
// retimes the multiplier output through an extra register (latency +1).
// ---------------------------------------------------------------------------
module mult_share_rr
    import mult_share_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [2*DATA_WIDTH-1:0]       rsp_y,
    output logic                          busy
);

    localparam int PW = 2 * DATA_WIDTH;

    state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [ID_WIDTH-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_WIDTH-1:0] a_q, a_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [PW-1:0]         y_q, y_d;
    logic [PW-1:0]         product;
`ifdef MULT_SHARE_PIPE_EN
    logic [PW-1:0]         prod_q, prod_d;
`endif

    logic [DATA_WIDTH-1:0] a_vec [NUM_REQ];
    logic [DATA_WIDTH-1:0] b_vec [NUM_REQ];
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  grant_found;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_arb (
        .req_valid   (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_found (grant_found)
    );

    // Unpack the flat operand buses so the winner can be selected by index.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            a_vec[i] = req_a[i*DATA_WIDTH +: DATA_WIDTH];
            b_vec[i] = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Operands are zero-extended first so the product keeps its full width.
    assign product = PW'(a_q) * PW'(b_q);

    // Next-state logic; registers hold unless the current state updates them.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        id_d     = id_q;
        rsp_id_d = rsp_id_q;
        a_d      = a_q;
        b_d      = b_q;
        y_d      = y_q;
`ifdef MULT_SHARE_PIPE_EN
        prod_d   = prod_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    a_d      = a_vec[grant_id];
                    b_d      = b_vec[grant_id];
                    id_d     = grant_id;
                    rr_ptr_d = ID_WIDTH'(rr_next_ptr(int'(grant_id), NUM_REQ));
                    state_d  = MUL;
                end
            end
            MUL: begin
`ifdef MULT_SHARE_PIPE_EN
                prod_d   = product;
                state_d  = MUL2;
`else
                y_d      = product;
                rsp_id_d = id_q;
                state_d  = RESP;
`endif
            end
            MUL2: begin
`ifdef MULT_SHARE_PIPE_EN
                y_d      = prod_q;
                rsp_id_d = id_q;
                state_d  = RESP;
`else
                state_d  = IDLE;
`endif
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            id_q     <= '0;
            rsp_id_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
`ifdef MULT_SHARE_PIPE_EN
            prod_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            rsp_id_q <= rsp_id_d;
            a_q      <= a_d;
            b_q      <= b_d;
            y_q      <= y_d;
`ifdef MULT_SHARE_PIPE_EN
            prod_q   <= prod_d;
`endif
        end
    end

    // Grants are only offered in IDLE, so a new grant never overlaps a
    // response handshake.
    assign req_ready = (state_q == IDLE) ? grant : '0;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_y     = y_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_share_rr.sv
// ---------------------------------------------------------------------------
// tb_mult_share_rr
// Directed self-checking bench for mult_share_rr (DATA_WIDTH=2, NUM_REQ=4).
// Honours MULT_SHARE_PIPE_EN for the extra MUL2 cycle.
// ---------------------------------------------------------------------------
module tb_mult_share_rr;

    logic       clk;
    logic       rst_n;
    logic [3:0] req_valid;
    logic [3:0] req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_id;
    logic [3:0] rsp_y;
    logic       busy;

    int errorCount = 0;
    int checkCount = 0;

    mult_share_rr #(
        .DATA_WIDTH (2),
        .NUM_REQ    (4),
        .ID_WIDTH   (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .busy      (busy)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keeps the run bounded no matter what the DUT does.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] pack4(input logic [1:0] v0, input logic [1:0] v1,
                                         input logic [1:0] v2, input logic [1:0] v3);
        return {v3, v2, v1, v0};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] valid, input logic [7:0] a,
                                 input logic [7:0] b, input logic rdy);
        req_valid = valid;
        req_a     = a;
        req_b     = b;
        rsp_ready = rdy;
    endtask

    // Called at a negedge in IDLE with the request already driven. Follows
    // one transaction through grant, multiply, (hold) response and return
    // to IDLE. validAfter/aAfter are applied right after the grant edge.
    task automatic serve(input int expId, input int expY, input int hold,
                         input logic [3:0] validAfter, input logic [7:0] aAfter);
        rsp_ready = (hold == 0);
        #1;
        checkOutput("grant", req_ready, 32'(1) << expId);
        checkOutput("busy_idle", busy, 0);
        @(negedge clk);
        req_valid = validAfter;
        req_a     = aAfter;
        #1;
        checkOutput("ready_mul", req_ready, 0);
        checkOutput("valid_mul", rsp_valid, 0);
        checkOutput("busy_mul", busy, 1);
`ifdef MULT_SHARE_PIPE_EN
        @(negedge clk);
        checkOutput("valid_mul2", rsp_valid, 0);
`endif
        @(negedge clk);
        checkOutput("valid_resp", rsp_valid, 1);
        checkOutput("rsp_y", rsp_y, expY);
        checkOutput("rsp_id", rsp_id, expId);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checkOutput("hold_valid", rsp_valid, 1);
            checkOutput("hold_y", rsp_y, expY);
            checkOutput("hold_id", rsp_id, expId);
            checkOutput("hold_ready", req_ready, 0);
            checkOutput("hold_busy", busy, 1);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("valid_done", rsp_valid, 0);
        checkOutput("busy_done", busy, 0);
    endtask

    initial begin
        logic [7:0] aVec;
        logic [7:0] bVec;

        rst_n = 1'b0;
        applyStimulus(4'b0000, 8'h00, 8'h00, 1'b0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_valid", rsp_valid, 0);
        checkOutput("rst_y", rsp_y, 0);
        checkOutput("rst_id", rsp_id, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_ready", req_ready, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_no_req", req_ready, 0);

        // Single requester 2: 3*3 = 9; rr_ptr becomes 3.
        $display("[TB] single requester");
        aVec = pack4(2'd0, 2'd0, 2'd3, 2'd0);
        bVec = pack4(2'd0, 2'd0, 2'd3, 2'd0);
        applyStimulus(4'b0100, aVec, bVec, 1'b1);
        serve(2, 9, 0, 4'b0000, aVec);

        // Requester 3 withdraws before its grant edge; requester 1 wins
        // (2*1 = 2) and rr_ptr becomes 2.
        $display("[TB] skip and wrap");
        applyStimulus(4'b1000, pack4(2'd0, 2'd0, 2'd0, 2'd3), 8'h00, 1'b1);
        #1;
        checkOutput("pre_grant3", req_ready, 4'b1000);
        aVec = pack4(2'd0, 2'd2, 2'd0, 2'd0);
        bVec = pack4(2'd0, 2'd1, 2'd0, 2'd0);
        applyStimulus(4'b0010, aVec, bVec, 1'b1);
        serve(1, 2, 0, 4'b0000, aVec);

        // With rr_ptr=2 and requesters 1,2 valid, 2 wins. Its a changes from
        // 1 to 3 after the grant: product must use 1*3 = 3. Held 5 cycles.
        $display("[TB] backpressure and operand change");
        aVec = pack4(2'd0, 2'd2, 2'd1, 2'd0);
        bVec = pack4(2'd0, 2'd2, 2'd3, 2'd0);
        applyStimulus(4'b0110, aVec, bVec, 1'b0);
        serve(2, 3, 5, 4'b0000, pack4(2'd0, 2'd2, 2'd3, 2'd0));

        // Reset while in MUL: everything clears, no late response.
        $display("[TB] reset mid-operation");
        aVec = pack4(2'd2, 2'd0, 2'd0, 2'd0);
        bVec = pack4(2'd2, 2'd0, 2'd0, 2'd0);
        applyStimulus(4'b0001, aVec, bVec, 1'b1);
        #1;
        checkOutput("rst_op_grant", req_ready, 4'b0001);
        @(negedge clk);
        checkOutput("rst_op_busy_before", busy, 1);
        rst_n     = 1'b0;
        req_valid = 4'b0000;
        #1;
        checkOutput("rst_op_busy", busy, 0);
        checkOutput("rst_op_valid", rsp_valid, 0);
        checkOutput("rst_op_y", rsp_y, 0);
        checkOutput("rst_op_id", rsp_id, 0);
        checkOutput("rst_op_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("post_rst_valid", rsp_valid, 0);
            checkOutput("post_rst_busy", busy, 0);
        end

        // All requesters valid: requester i has a=i, b=3. rr_ptr is 0 after
        // reset, so the order is 0,1,2,3,0 with products 0,3,6,9,0.
        $display("[TB] all requesters continuous");
        aVec = pack4(2'd0, 2'd1, 2'd2, 2'd3);
        bVec = pack4(2'd3, 2'd3, 2'd3, 2'd3);
        applyStimulus(4'b1111, aVec, bVec, 1'b1);
        serve(0, 0, 0, 4'b1111, aVec);
        serve(1, 3, 0, 4'b1111, aVec);
        serve(2, 6, 0, 4'b1111, aVec);
        serve(3, 9, 0, 4'b1111, aVec);
        serve(0, 0, 0, 4'b0000, aVec);

        // Maximum operands on requester 3 (rr_ptr=1 scans 1,2,3): 3*3 = 9.
        $display("[TB] max operands");
        aVec = pack4(2'd0, 2'd0, 2'd0, 2'd3);
        bVec = pack4(2'd0, 2'd0, 2'd0, 2'd3);
        applyStimulus(4'b1000, aVec, bVec, 1'b1);
        serve(3, 9, 0, 4'b0000, aVec);

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
